imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Controller that owns the instruction-memory write port during program download. It consumes the UART receiver's byte stream, frames and validates a download packet, assembles little-endian 32-bit words, and sequences them into instruction memory. It holds the pipeline stalled for the whole transfer, answers ACK/NAK through the UART transmitter, and restarts the core with a timed reset pulse. It sits between the UART byte interface and the `imem_WE`/`imem_A`/`imem_WD`/`cpu_stall`/`prog_mode` signals of the processor top level.

## Interface
- `IMEM_BASE`, 32'h0000_0000, byte address of the first downloaded word
- `MAX_WORDS`, 256, largest accepted word count
- `SYNC_BYTE`, 8'hA5, packet start marker
- `TIMEOUT_CYCLES`, 1000000, maximum idle cycles between bytes inside a packet
- `RST_CYCLES`, 4, length of the `core_reset` pulse

- `CLK` in 1: the only clock.
- `reset` in 1: asynchronous, active-high.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is a received byte.
- `rx_data` in 8: received byte.
- `tx_ready` in 1: the UART transmitter accepts `tx_data`.
- `tx_valid` out 1: a response byte is pending.
- `tx_data` out 8: response byte, 8'h06 = ACK, 8'h15 = NAK.
- `imem_WE` out 1: instruction-memory write strobe.
- `imem_A` out 32: instruction-memory write byte address.
- `imem_WD` out 32: instruction-memory write data.
- `prog_mode` out 1: a download is in progress.
- `cpu_stall` out 1: freezes the fetch and decode stages; always equal to `prog_mode`.
- `core_reset` out 1: resets the core after a successful load.
- `load_done` out 1: one-cycle pulse when the core is released.
- `load_error` out 1: sticky error flag; cleared when the next sync byte is accepted.

## Operation
- Packet format, in order:
  - `SYNC_BYTE`
  - LEN_LO, LEN_HI: word count N, 16-bit
  - 4·N data bytes, little-endian per word (first byte goes to bits [7:0])
  - CSUM: the sum of all data bytes mod 256
- State machine: IDLE, LEN0, LEN1, DATA, WRITE, CSUM, RESP, RST.
- IDLE:
  - Bytes other than `SYNC_BYTE` are ignored.
  - On `SYNC_BYTE`, go to LEN0. Set `prog_mode`, clear `load_error`, clear the word index, byte counter and checksum.
- LEN0 → LEN1 → after LEN_HI, validate N:
  - N == 0 or N > `MAX_WORDS`: set `load_error`, go to RESP with NAK.
  - Otherwise go to DATA.
- DATA:
  - Each byte is shifted into the word register and added to the 8-bit checksum (wraps mod 256).
  - On the 4th byte, go to WRITE.
- WRITE (one cycle):
  - `imem_WE`=1, `imem_A` = `IMEM_BASE` + 4·index, `imem_WD` = the assembled word.
  - Then increment the index. If index == N go to CSUM, else DATA.
- CSUM:
  - Byte equals the running checksum: go to RESP with ACK.
  - Otherwise set `load_error` and go to RESP with NAK.
- RESP:
  - Hold `tx_valid`=1 with a stable `tx_data` until `tx_valid`&&`tx_ready`.
  - After ACK go to RST.
  - After NAK go to IDLE with `prog_mode` still 1. The core stays stalled until a valid retry.
- RST:
  - `core_reset`=1 for exactly `RST_CYCLES` cycles.
  - On the cycle `core_reset` falls: `prog_mode`/`cpu_stall` go to 0, `load_done` pulses, go to IDLE.
- Timeout:
  - In LEN0, LEN1, DATA or CSUM, an idle counter counts cycles without `rx_valid`. It is cleared on each byte.
  - Reaching `TIMEOUT_CYCLES` sets `load_error` and goes to RESP with NAK.
- Bytes arriving in WRITE, RESP or RST are dropped.
- A `SYNC_BYTE` value inside LEN/DATA/CSUM is treated as data. It is not a restart.
- Words already written before a NAK stay in memory. A retry overwrites them.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-packet abandons the packet with no further writes, and the core is not stalled.
- `imem_WE` rises in the cycle after the `rx_valid` of the 4th byte of a word, and lasts exactly 1 cycle.
- `prog_mode` rises in the cycle after the sync byte's `rx_valid`.
- `tx_valid` rises in the cycle after the CSUM/LEN_HI byte or after the timeout.
- ACK handshake cycle → `core_reset` high the next cycle, for `RST_CYCLES`.
- `rx_valid` is at most 1 per cycle. The minimum UART byte spacing is far more than 2 cycles, so WRITE never drops a valid byte in normal use.
- `imem_A` and `imem_WD` are registered, and hold their last value when `imem_WE`=0.

## Test plan
- Valid 2-word load, N=2, data 13 00 00 00 / 6F 00 00 00, CSUM 8'h82. Required:
  - 2 writes: A=0 WD=32'h00000013, then A=4 WD=32'h0000006F.
  - TX byte 06.
  - `core_reset` high 4 cycles, then `load_done` pulse; `prog_mode` 0.
- Bad checksum, same packet with CSUM 8'h83. Required:
  - Both writes occur, TX 15.
  - `load_error`=1, `prog_mode` stays 1, no `core_reset`.
- Length errors:
  - N=0 → NAK, no writes.
  - N=257 → NAK, no writes.
  - A subsequent valid packet → ACK and `load_error` cleared.
- Timeout:
  - Setup: `TIMEOUT_CYCLES`=100, sync, LEN 01 00, two data bytes, then silence.
  - Required: NAK after exactly 100 idle cycles, no write.
- Backpressure and reset:
  - `tx_ready` held low 50 cycles: `tx_valid`/`tx_data` stay stable.
  - Async `reset` pulse during DATA: all outputs 0 immediately, and no `imem_WE` afterwards.
- Noise in IDLE: bytes 00 FF 5A are ignored, with `prog_mode` 0 throughout; a following `SYNC_BYTE` starts a packet.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Download controller: frames UART bytes into a length/data/checksum packet,
// writes little-endian words into instruction memory and restarts the core.
module imem_boot_loader #(
  parameter logic [31:0] IMEM_BASE      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 256,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RST_CYCLES     = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        imem_WE,
  output logic [31:0] imem_A,
  output logic [31:0] imem_WD,
  output logic        prog_mode,
  output logic        cpu_stall,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_error
);

  localparam logic [7:0]  ACK = 8'h06;
  localparam logic [7:0]  NAK = 8'h15;
  localparam int unsigned IW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, RESP, RST} state_t;

  state_t        state, stateNext;
  logic [IW-1:0] idleCnt;
  logic [RW-1:0] rstCnt;
  logic [7:0]    lenLo;
  logic [15:0]   wordCount;
  logic [15:0]   index;
  logic [1:0]    byteCnt;
  logic [7:0]    csum;
  logic [23:0]   word;
  logic [7:0]    txByte;

  logic [15:0]   lenWord;
  logic [15:0]   indexInc;
  logic          lenBad;
  logic          waiting;
  logic          timeout;
  logic          syncHit;
  logic          rstLast;

  always_comb begin
    lenWord  = {rx_data, lenLo};
    indexInc = index + 16'd1;
    lenBad   = (lenWord == 16'd0) || ({16'd0, lenWord} > MAX_WORDS);
    waiting  = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
    timeout  = waiting && !rx_valid && (idleCnt == IW'(TIMEOUT_CYCLES - 1));
    syncHit  = (state == IDLE) && rx_valid && (rx_data == SYNC_BYTE);
    rstLast  = (rstCnt == RW'(RST_CYCLES - 1));
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (syncHit) stateNext = LEN0;
      LEN0:  if (rx_valid) stateNext = LEN1;
             else if (timeout) stateNext = RESP;
      LEN1:  if (rx_valid) stateNext = lenBad ? RESP : DATA;
             else if (timeout) stateNext = RESP;
      DATA:  if (rx_valid && byteCnt == 2'd3) stateNext = WRITE;
             else if (timeout) stateNext = RESP;
      WRITE: stateNext = (indexInc == wordCount) ? CSUM : DATA;
      CSUM:  if (rx_valid || timeout) stateNext = RESP;
      RESP:  if (tx_ready) stateNext = (txByte == ACK) ? RST : IDLE;
      RST:   if (rstLast) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  assign tx_valid   = (state == RESP);
  assign tx_data    = txByte;
  assign imem_WE    = (state == WRITE);
  assign core_reset = (state == RST);
  assign cpu_stall  = prog_mode;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      idleCnt    <= '0;
      rstCnt     <= '0;
      lenLo      <= '0;
      wordCount  <= '0;
      index      <= '0;
      byteCnt    <= '0;
      csum       <= '0;
      word       <= '0;
      txByte     <= '0;
      imem_A     <= '0;
      imem_WD    <= '0;
      prog_mode  <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (!waiting || rx_valid) idleCnt <= '0;
      else                      idleCnt <= idleCnt + IW'(1);

      unique case (state)
        IDLE: if (syncHit) begin
          prog_mode  <= 1'b1;
          load_error <= 1'b0;
          index      <= '0;
          byteCnt    <= '0;
          csum       <= '0;
        end
        LEN0: if (rx_valid) lenLo <= rx_data;
        LEN1: if (rx_valid) begin
          wordCount <= lenWord;
          if (lenBad) begin
            load_error <= 1'b1;
            txByte     <= NAK;
          end
        end
        // Bytes shift in from the top so the first byte lands in bits [7:0].
        DATA: if (rx_valid) begin
          word    <= {rx_data, word[23:8]};
          csum    <= csum + rx_data;
          byteCnt <= byteCnt + 2'd1;
          if (byteCnt == 2'd3) begin
            imem_WD <= {rx_data, word};
            imem_A  <= IMEM_BASE + {14'd0, index, 2'b00};
          end
        end
        WRITE: index <= indexInc;
        CSUM: if (rx_valid) begin
          if (rx_data == csum) txByte <= ACK;
          else begin
            txByte     <= NAK;
            load_error <= 1'b1;
          end
        end
        RST: begin
          if (rstLast) begin
            rstCnt    <= '0;
            prog_mode <= 1'b0;
            load_done <= 1'b1;
          end else begin
            rstCnt <= rstCnt + RW'(1);
          end
        end
        default: ;
      endcase

      if (timeout) begin
        load_error <= 1'b1;
        txByte     <= NAK;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes and response bytes
// are queued as packets are sent and checked when the loader produces them.
module tb_imem_boot_loader;

  localparam int GAP = 4;

  logic        CLK, reset, rx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        tx_valid, imem_WE, prog_mode, cpu_stall, core_reset, load_done, load_error;
  logic [7:0]  tx_data;
  logic [31:0] imem_A, imem_WD;

  imem_boot_loader #(
    .IMEM_BASE(32'h0000_0000),
    .MAX_WORDS(256),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(100),
    .RST_CYCLES(4)
  ) dut (
    .CLK(CLK), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .imem_WE(imem_WE), .imem_A(imem_A), .imem_WD(imem_WD),
    .prog_mode(prog_mode), .cpu_stall(cpu_stall), .core_reset(core_reset),
    .load_done(load_done), .load_error(load_error)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t        wrQ[$];
  logic [7:0] txQ[$];
  logic [7:0] dataBuf[0:15];

  int vecCount = 0, missCount = 0;
  int wrExtra = 0, txExtra = 0, txCount = 0, doneCycles = 0, crPulses = 0;
  int crLen = 0, stallMis = 0, bpBad = 0;
  bit crPrev = 0, ackPend = 0;
  logic postWE, postTxV, postPM, postLE;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (ackPend) begin
      checkEq("cr_after_ack", core_reset, 1);
      ackPend = 0;
    end
    if (cpu_stall !== prog_mode) stallMis++;
    if (load_done) doneCycles++;
    if (imem_WE) begin
      if (wrQ.size() == 0) wrExtra++;
      else begin
        wr_t e;
        e = wrQ.pop_front();
        checkEq("wr_addr", imem_A, e.a);
        checkEq("wr_data", imem_WD, e.d);
      end
    end
    if (tx_valid && tx_ready) begin
      txCount++;
      if (txQ.size() == 0) txExtra++;
      else begin
        logic [7:0] e;
        e = txQ.pop_front();
        checkEq("tx_byte", tx_data, e);
        if (e == 8'h06) ackPend = 1;
      end
    end
    if (core_reset) crLen++;
    if (crPrev && !core_reset) begin
      crPulses++;
      checkEq("rst_len", crLen, 4);
      checkEq("done_at_fall", load_done, 1);
      checkEq("pm_at_fall", prog_mode, 0);
      crLen = 0;
    end
    crPrev = core_reset;
  end

  task automatic sendByte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
    postWE  = imem_WE;
    postTxV = tx_valid;
    postPM  = prog_mode;
    postLE  = load_error;
    repeat (GAP) @(posedge CLK);
    #1;
  endtask

  task automatic sendPkt(input logic [15:0] len, input int nb, input logic [7:0] cs, input bit lenErr);
    sendByte(8'hA5);
    checkEq("pm_rise", postPM, 1);
    checkEq("le_clear", postLE, 0);
    sendByte(len[7:0]);
    sendByte(len[15:8]);
    if (lenErr) begin
      checkEq("txv_after_len", postTxV, 1);
      return;
    end
    for (int i = 0; i < nb; i++) begin
      sendByte(dataBuf[i]);
      if (i % 4 == 3) checkEq("we_latency", postWE, 1);
    end
    sendByte(cs);
    checkEq("txv_after_csum", postTxV, 1);
  endtask

  task automatic waitTx(input int target);
    int n = 0;
    while (txCount < target && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    checkEq("tx_seen", txCount, target);
  endtask

  task automatic waitDone(input int target);
    int n = 0;
    while (doneCycles < target && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    checkEq("done_seen", doneCycles, target);
  endtask

  task automatic loadTwoWords(input logic [7:0] cs);
    dataBuf[0] = 8'h13; dataBuf[1] = 8'h00; dataBuf[2] = 8'h00; dataBuf[3] = 8'h00;
    dataBuf[4] = 8'h6F; dataBuf[5] = 8'h00; dataBuf[6] = 8'h00; dataBuf[7] = 8'h00;
    wrQ.push_back('{a: 32'h0, d: 32'h0000_0013});
    wrQ.push_back('{a: 32'h4, d: 32'h0000_006F});
    sendPkt(16'd2, 8, cs, 0);
  endtask

  initial begin
    int base;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    #12;
    checkEq("rst_ctrl", {tx_valid, imem_WE, prog_mode, cpu_stall, core_reset, load_done, load_error, tx_data}, 0);
    checkEq("rst_addr", imem_A, 0);
    checkEq("rst_wd", imem_WD, 0);
    #5 reset = 1'b0;
    @(posedge CLK); #1;

    // IDLE noise
    sendByte(8'h00); checkEq("noise_pm_00", postPM, 0);
    sendByte(8'hFF); checkEq("noise_pm_ff", postPM, 0);
    sendByte(8'h5A); checkEq("noise_pm_5a", postPM, 0);

    // valid 2-word load
    txQ.push_back(8'h06);
    loadTwoWords(8'h82);
    waitTx(1);
    waitDone(1);
    checkEq("pm_after_load", prog_mode, 0);
    checkEq("le_after_load", load_error, 0);

    // bad checksum
    txQ.push_back(8'h15);
    loadTwoWords(8'h83);
    waitTx(2);
    repeat (10) @(posedge CLK);
    #1;
    checkEq("le_bad_csum", load_error, 1);
    checkEq("pm_bad_csum", prog_mode, 1);
    checkEq("no_cr_bad_csum", crPulses, 1);

    // length errors, then a valid retry
    txQ.push_back(8'h15);
    sendPkt(16'd0, 0, 8'h00, 1);
    waitTx(3);
    checkEq("le_len0", load_error, 1);
    txQ.push_back(8'h15);
    sendPkt(16'd257, 0, 8'h00, 1);
    waitTx(4);
    checkEq("le_len257", load_error, 1);
    dataBuf[0] = 8'hEF; dataBuf[1] = 8'hBE; dataBuf[2] = 8'hAD; dataBuf[3] = 8'hDE;
    wrQ.push_back('{a: 32'h0, d: 32'hDEAD_BEEF});
    txQ.push_back(8'h06);
    sendPkt(16'd1, 4, 8'h38, 0);
    waitTx(5);
    waitDone(2);
    checkEq("le_after_retry", load_error, 0);
    checkEq("pm_after_retry", prog_mode, 0);

    // timeout after two data bytes
    txQ.push_back(8'h15);
    sendByte(8'hA5);
    sendByte(8'h01);
    sendByte(8'h00);
    sendByte(8'h11);
    rx_valid = 1'b1; rx_data = 8'h22;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
    repeat (99) @(posedge CLK);
    #1;
    checkEq("timeout_early", tx_valid, 0);
    @(posedge CLK); #1;
    checkEq("timeout_exact", tx_valid, 1);
    checkEq("timeout_txd", tx_data, 8'h15);
    waitTx(6);
    checkEq("le_timeout", load_error, 1);

    // backpressure on the response
    tx_ready = 1'b0;
    base = txCount;
    txQ.push_back(8'h15);
    sendPkt(16'd0, 0, 8'h00, 1);
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK); #1;
      if (tx_valid !== 1'b1 || tx_data !== 8'h15) bpBad++;
    end
    checkEq("bp_stable", bpBad, 0);
    checkEq("bp_no_handshake", txCount, base);
    tx_ready = 1'b1;
    waitTx(base + 1);

    // async reset in the middle of DATA
    sendByte(8'hA5);
    sendByte(8'h02);
    sendByte(8'h00);
    sendByte(8'h11);
    sendByte(8'h22);
    #2 reset = 1'b1;
    #1;
    checkEq("mid_rst_ctrl", {tx_valid, imem_WE, prog_mode, cpu_stall, core_reset, load_done, load_error, tx_data}, 0);
    checkEq("mid_rst_addr", imem_A, 0);
    checkEq("mid_rst_wd", imem_WD, 0);
    #6 reset = 1'b0;
    @(posedge CLK); #1;
    sendByte(8'h33);
    sendByte(8'h44);
    sendByte(8'h55);
    sendByte(8'h66);
    checkEq("pm_after_rst", prog_mode, 0);

    repeat (10) @(posedge CLK);
    #1;
    checkEq("wr_left", wrQ.size(), 0);
    checkEq("tx_left", txQ.size(), 0);
    checkEq("extra_writes", wrExtra, 0);
    checkEq("extra_tx", txExtra, 0);
    checkEq("done_cycles", doneCycles, 2);
    checkEq("cr_pulses", crPulses, 2);
    checkEq("stall_eq_pm", stallMis, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vecCount);
    $fatal(1);
  end

endmodule
